// File: rtl/inst_fetch.sv
// Instruction fetch unit placed in front of the multi-cycle rv32 core.
// Each accepted fetch issues one word-aligned read on a valid/ready request
// channel and waits for the response. The core receives a registered
// instruction with a valid flag. Misaligned PCs, bus errors and response
// timeouts all deliver NOP_INST with the fault flag set, so the core never
// consumes undefined data.
module inst_fetch #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_start,
   input  logic [31:0] pc_in,
   output logic [31:0] inst_out,
   output logic        inst_valid,
   output logic        busy,
   output logic        fault,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RESP  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   // The wait counter is 8 bits wide and saturates at this limit.
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_e      state_q, state_d;
   logic [31:0] inst_q, inst_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  cnt_inc;

   // State and output registers, synchronous active-high reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before the edge.
      if (rst) begin
         state_q     <= IDLE;
         inst_q      <= NOP_INST;
         valid_q     <= 1'b0;
         fault_q     <= 1'b0;
         req_valid_q <= 1'b0;
         addr_q      <= 32'h0;
         cnt_q       <= 8'h0;
      end else begin
         state_q     <= state_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
         fault_q     <= fault_d;
         req_valid_q <= req_valid_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
      end
   end

   // Saturating increment of the response wait counter.
   always_comb begin
      cnt_inc = (cnt_q == TIMEOUT_CNT) ? cnt_q : cnt_q + 8'd1;
   end

   // Next-state and next-output logic of the fetch FSM.
   always_comb begin
      // NOTE: every target gets a hold-value default first, so no path
      // through the case statement can infer a latch.
      state_d     = state_q;
      inst_d      = inst_q;
      valid_d     = valid_q;
      fault_d     = fault_q;
      req_valid_d = req_valid_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (fetch_start) begin
               if (pc_in[1:0] != 2'b00) begin
                  // Misaligned: report the fault right away, no bus traffic.
                  inst_d  = NOP_INST;
                  fault_d = 1'b1;
                  valid_d = 1'b1;
               end else begin
                  valid_d     = 1'b0;
                  fault_d     = 1'b0;
                  addr_d      = pc_in;
                  req_valid_d = 1'b1;
                  state_d     = REQ;
               end
            end
         end

         REQ: begin
            // The address stays stable until the memory accepts it.
            if (imem_req_ready) begin
               req_valid_d = 1'b0;
               cnt_d       = 8'h0;
               state_d     = RESP;
            end
         end

         RESP: begin
            cnt_d = cnt_inc;
            if (imem_resp_valid) begin
               inst_d  = imem_resp_err ? NOP_INST : imem_resp_data;
               fault_d = imem_resp_err;
               valid_d = 1'b1;
               state_d = IDLE;
            end else if (cnt_inc == TIMEOUT_CNT) begin
               inst_d  = NOP_INST;
               fault_d = 1'b1;
               valid_d = 1'b1;
               state_d = DRAIN;
            end
         end

         DRAIN: begin
            // The timed-out read is still outstanding: swallow its answer.
            if (imem_resp_valid) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign inst_out       = inst_q;
   assign inst_valid     = valid_q;
   assign fault          = fault_q;
   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = addr_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch. It runs directed scenarios with literal expected
// values, then a long randomized run. A transaction-level reference model
// tracks the outstanding fetch and is compared with the DUT every cycle.
module tb_inst_fetch;

   localparam int unsigned TIMEOUT  = 8;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_start;
   logic [31:0] pc_in;
   logic [31:0] inst_out;
   logic        inst_valid;
   logic        busy;
   logic        fault;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   inst_fetch #(.TIMEOUT(TIMEOUT), .NOP_INST(NOP_INST)) dut (
      .clk             (clk),
      .rst             (rst),
      .fetch_start     (fetch_start),
      .pc_in           (pc_in),
      .inst_out        (inst_out),
      .inst_valid      (inst_valid),
      .busy            (busy),
      .fault           (fault),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. It tracks three facts: whether a request is still
   // being offered, how many cycles the accepted request has waited
   // (-1 = none), and whether a timed-out request is still owed an answer.
   logic [31:0] m_inst, m_addr;
   bit          m_valid, m_fault, m_offer, m_orphan;
   int          m_age;

   always @(posedge clk) begin
      if (rst) begin
         m_inst = NOP_INST; m_valid = 0; m_fault = 0; m_addr = 0;
         m_offer = 0; m_age = -1; m_orphan = 0;
      end else if (m_offer) begin
         if (imem_req_ready) begin
            m_offer = 0;
            m_age   = 0;
         end
      end else if (m_age >= 0) begin
         if (imem_resp_valid) begin
            m_inst  = imem_resp_err ? NOP_INST : imem_resp_data;
            m_fault = imem_resp_err;
            m_valid = 1;
            m_age   = -1;
         end else if (m_age + 1 == int'(TIMEOUT)) begin
            m_inst = NOP_INST; m_fault = 1; m_valid = 1;
            m_age  = -1;
            m_orphan = 1;
         end else begin
            m_age++;
         end
      end else if (m_orphan) begin
         if (imem_resp_valid) m_orphan = 0;
      end else if (fetch_start) begin
         if (pc_in[1:0] != 2'b00) begin
            m_inst = NOP_INST; m_fault = 1; m_valid = 1;
         end else begin
            m_addr = pc_in; m_offer = 1; m_valid = 0; m_fault = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_inst_out",   inst_out,       m_inst);
         check("m_inst_valid", 32'(inst_valid), 32'(m_valid));
         check("m_fault",      32'(fault),     32'(m_fault));
         check("m_busy",       32'(busy),      32'(m_offer || m_age >= 0 || m_orphan));
         check("m_req_valid",  32'(imem_req_valid), 32'(m_offer));
         if (m_offer) check("m_req_addr", imem_req_addr, m_addr);
      end
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic cyc(input logic r, input logic fs, input logic [31:0] pc,
                      input logic rdy, input logic rv, input logic [31:0] rd,
                      input logic re);
      @(posedge clk);
      #1;
      rst = r; fetch_start = fs; pc_in = pc; imem_req_ready = rdy;
      imem_resp_valid = rv; imem_resp_data = rd; imem_resp_err = re;
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   // Zero-wait fetch: returns in cycle 3, where the result must be visible.
   task automatic fetch_zero(input logic [31:0] pc, input logic [31:0] data, input logic err);
      cyc(1'b0, 1'b1, pc, 1'b1, 1'b0, 32'h0, 1'b0);
      idle();
      check("zw_req_valid_c1", 32'(imem_req_valid), 32'd1);
      check("zw_req_addr_c1",  imem_req_addr, pc);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, data, err);
      check("zw_busy_c2", 32'(busy), 32'd1);
      idle();
   endtask

   initial begin
      logic [31:0] pc_r;
      int          resp_pct;
      rst = 1'b1; fetch_start = 0; pc_in = 0; imem_req_ready = 0;
      imem_resp_valid = 0; imem_resp_data = 0; imem_resp_err = 0;

      // Reset state.
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk_en = 1'b1;
      idle();
      check("rst_inst_out",   inst_out, NOP_INST);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_fault",      32'(fault), 32'd0);
      check("rst_busy",       32'(busy), 32'd0);
      check("rst_req_valid",  32'(imem_req_valid), 32'd0);
      check("rst_req_addr",   imem_req_addr, 32'h0);

      // Zero-wait fetch.
      fetch_zero(32'h8000_0000, 32'h0010_0093, 1'b0);
      check("zw_inst_out", inst_out, 32'h0010_0093);
      check("zw_valid",    32'(inst_valid), 32'd1);
      check("zw_fault",    32'(fault), 32'd0);
      check("zw_busy_c3",  32'(busy), 32'd0);

      // Backpressure: ready low for 4 cycles, then one handshake.
      cyc(1'b0, 1'b1, 32'h0000_1000, 1'b0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         check("bp_req_valid", 32'(imem_req_valid), 32'd1);
         check("bp_addr_stable", imem_req_addr, 32'h0000_1000);
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("bp_one_handshake", 32'(imem_req_valid), 32'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0020_0113, 1'b0);
      check("bp_valid_before", 32'(inst_valid), 32'd0);
      idle();
      check("bp_valid_after", 32'(inst_valid), 32'd1);
      check("bp_inst_out",    inst_out, 32'h0020_0113);

      // Misaligned PC.
      cyc(1'b0, 1'b1, 32'h8000_0002, 1'b1, 1'b0, 32'h0, 1'b0);
      idle();
      check("mis_fault",     32'(fault), 32'd1);
      check("mis_valid",     32'(inst_valid), 32'd1);
      check("mis_inst",      inst_out, 32'h0000_0013);
      check("mis_req_valid", 32'(imem_req_valid), 32'd0);
      idle();
      check("mis_req_valid2", 32'(imem_req_valid), 32'd0);

      // Bus error.
      fetch_zero(32'h0000_0040, 32'hFFFF_FFFF, 1'b1);
      check("err_inst",  inst_out, 32'h0000_0013);
      check("err_fault", 32'(fault), 32'd1);
      check("err_valid", 32'(inst_valid), 32'd1);

      // Timeout and drain: handshake in cycle 1, fault in cycle 10.
      cyc(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b0);
      idle();
      for (int i = 2; i <= 9; i++) idle();
      check("to_fault_c9", 32'(fault), 32'd0);
      idle();
      check("to_fault_c10", 32'(fault), 32'd1);
      check("to_valid_c10", 32'(inst_valid), 32'd1);
      check("to_inst_c10",  inst_out, NOP_INST);
      check("to_busy_c10",  32'(busy), 32'd1);
      cyc(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0, 1'b0);
      idle();
      check("drain_ignore_fs", 32'(imem_req_valid), 32'd0);
      check("drain_busy",      32'(busy), 32'd1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
      idle();
      check("drain_busy_off", 32'(busy), 32'd0);
      check("drain_inst",     inst_out, NOP_INST);
      fetch_zero(32'h0000_0300, 32'h00A0_0513, 1'b0);
      check("post_drain_inst",  inst_out, 32'h00A0_0513);
      check("post_drain_fault", 32'(fault), 32'd0);

      // Reset while waiting for the response.
      cyc(1'b0, 1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0, 1'b0);
      idle();
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      check("rm_busy",  32'(busy), 32'd0);
      check("rm_valid", 32'(inst_valid), 32'd0);
      check("rm_inst",  inst_out, 32'h0000_0013);
      idle();
      check("rm_trail_inst",  inst_out, 32'h0000_0013);
      check("rm_trail_valid", 32'(inst_valid), 32'd0);
      check("rm_trail_busy",  32'(busy), 32'd0);

      // Randomized run; sparse-response epochs provoke timeouts and drains.
      resp_pct = 35;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) resp_pct = (resp_pct == 35) ? 4 : 35;
         pc_r = $urandom;
         if ($urandom_range(0, 3) == 0) pc_r[1:0] = 2'($urandom_range(1, 3));
         else                           pc_r[1:0] = 2'b00;
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 30),
             pc_r,
             ($urandom_range(0, 99) < 60),
             ($urandom_range(0, 99) < resp_pct),
             $urandom,
             ($urandom_range(0, 9) == 0));
      end
      idle();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
